// File: rtl/fifo_wr_sdram_burst_pkg.sv
// fifo_wr_sdram_burst_pkg: shared state encodings and default widths for the cyp2sdram blocks
package fifo_wr_sdram_burst_pkg;
    localparam int unsigned DEF_DW = 16;
    localparam int unsigned DEF_AW = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
endpackage

// File: rtl/fifo_wr_sdram_burst_if.sv
// fifo_wr_sdram_burst_if: FIFO read side plus SDRAM write stream of the mover
interface fifo_wr_sdram_burst_if
    import fifo_wr_sdram_burst_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned AW = DEF_AW
);
    logic          fifo_ren;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rempty;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_valid;
    logic          wr_ready;
    logic          wr_last;
    modport master (
        output fifo_ren, wr_data, wr_addr, wr_valid, wr_last,
        input  fifo_rdata, fifo_rempty, wr_ready
    );
    modport slave (
        input  fifo_ren, wr_data, wr_addr, wr_valid, wr_last,
        output fifo_rdata, fifo_rempty, wr_ready
    );
endinterface

// File: rtl/fifo_wr_sdram_burst_fifo_rd_skid.sv
// fifo_rd_skid: two-entry buffer hiding the one-cycle FIFO read latency
module fifo_rd_skid #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          clear,
    input  logic          rempty,
    input  logic          ready,
    input  logic [DW-1:0] rdata,
    output logic          ren,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [1:0]    occ,
    output logic          inflight
);
    logic [DW-1:0] e1;
    logic          fire;
    logic [1:0]    slot;
    assign valid = occ != 2'd0;
    assign fire  = valid & ready;
    // slot the in-flight word lands in once this cycle's fire has shifted the buffer
    assign slot  = occ - 2'(fire);
    assign ren   = rst_n & enable & ~clear & ~rempty & (3'(occ) + 3'(inflight) < 3'd2 + 3'(fire));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            occ      <= '0;
            inflight <= 1'b0;
            data     <= '0;
            e1       <= '0;
        end else begin
            inflight <= ren;
            occ      <= clear ? 2'd0 : slot + 2'(inflight);
            if (!clear) begin
                data <= inflight && slot == 2'd0 ? rdata : fire ? e1 : data;
                e1   <= inflight && slot == 2'd1 ? rdata : e1;
            end
        end
endmodule

// File: rtl/fifo_wr_sdram_burst.sv
// fifo_wr_sdram_burst: moves CY68013 FIFO words into a burst-framed, ring-addressed SDRAM write stream
module fifo_wr_sdram_burst
    import fifo_wr_sdram_burst_pkg::*;
#(
    parameter int unsigned     DW           = DEF_DW,
    parameter int unsigned     AW           = DEF_AW,
    parameter longint unsigned BASE_ADDR    = 0,
    parameter int unsigned     REGION_WORDS = 4096,
    parameter int unsigned     BURST_LEN    = 8,
    parameter longint unsigned ADDR_STEP    = 1
) (
    input  logic                  sdram_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear,
    fifo_wr_sdram_burst_if.master bus,
    output logic                  wrap_pulse,
    output logic [31:0]           words_written
);
    state_t      state;
    logic [31:0] idx;
    logic [1:0]  occ;
    logic        inflight;
    logic        fire;
    logic        at_end;
    fifo_rd_skid #(.DW(DW)) u_skid (
        .clk      (sdram_clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .clear    (clear),
        .rempty   (bus.fifo_rempty),
        .ready    (bus.wr_ready),
        .rdata    (bus.fifo_rdata),
        .ren      (bus.fifo_ren),
        .valid    (bus.wr_valid),
        .data     (bus.wr_data),
        .occ      (occ),
        .inflight (inflight)
    );
    assign fire        = bus.wr_valid & bus.wr_ready;
    assign at_end      = idx == REGION_WORDS - 1;
    assign bus.wr_addr = AW'(BASE_ADDR + 64'(idx) * ADDR_STEP);
    assign bus.wr_last = bus.wr_valid & (idx % BURST_LEN == BURST_LEN - 1);
    // a fire coinciding with clear is dropped: it neither advances idx nor counts
    always_ff @(posedge sdram_clk or negedge rst_n)
        if (!rst_n) begin
            state         <= ST_IDLE;
            idx           <= '0;
            wrap_pulse    <= 1'b0;
            words_written <= '0;
        end else begin
            state <= clear              ? ST_IDLE :
                     state == ST_IDLE   ? (enable ? ST_RUN : ST_IDLE) :
                     state == ST_RUN    ? (enable ? ST_RUN : ST_DRAIN) :
                     enable             ? ST_RUN :
                     occ == 2'd0 && !inflight ? ST_IDLE : ST_DRAIN;
            idx           <= clear || (fire && at_end) ? '0 : fire ? idx + 1 : idx;
            wrap_pulse    <= fire & ~clear & at_end;
            words_written <= words_written + 32'(fire & ~clear);
        end
endmodule

// File: tb/tb_fifo_wr_sdram_burst.sv
// tb_fifo_wr_sdram_burst: randomized stream bench against a word-queue reference model
module tb_fifo_wr_sdram_burst;
    import fifo_wr_sdram_burst_pkg::*;
    localparam int unsigned     DW   = 16;
    localparam int unsigned     AW   = 32;
    localparam int unsigned     RW   = 16;
    localparam int unsigned     BL   = 8;
    localparam longint unsigned BASE = 64'h100;
    localparam longint unsigned STEP = 1;

    logic        sdram_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        wrap_pulse;
    logic [31:0] words_written;

    fifo_wr_sdram_burst_if #(.DW(DW), .AW(AW)) bus ();

    fifo_wr_sdram_burst #(
        .DW(DW), .AW(AW), .BASE_ADDR(BASE), .REGION_WORDS(RW), .BURST_LEN(BL), .ADDR_STEP(STEP)
    ) dut (
        .sdram_clk     (sdram_clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .clear         (clear),
        .bus           (bus),
        .wrap_pulse    (wrap_pulse),
        .words_written (words_written)
    );

    always #5 sdram_clk = ~sdram_clk;

    int n_cmp = 0, n_err = 0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    int k = 0, n_fired = 0, cyc = 0, wraps = 0;
    int first_ren_cyc, first_valid_cyc, first_fire_cyc, last_fire_cyc;
    logic [AW-1:0] first_fire_addr;
    logic last_ren = 1'b0, gap_mode = 1'b0, exp_wrap = 1'b0, prev_hold = 1'b0, prev_last;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: model FIFO source, check beats, then post-edge registered outputs
    task automatic cycle();
        logic ren, fire, ren_exp;
        bus.fifo_rempty = (src_q.size() == 0) || (gap_mode && cyc % 3 == 0);
        #1;
        ren     = bus.fifo_ren;
        fire    = bus.wr_valid & bus.wr_ready;
        ren_exp = enable && !clear && !bus.fifo_rempty && (exp_q.size() - int'(fire) < 2);
        check("fifo_ren", ren, ren_exp);
        check("wr_valid", bus.wr_valid, exp_q.size() - int'(last_ren) > 0);
        if (prev_hold) begin
            check("hold_data", bus.wr_data, prev_data);
            check("hold_addr", bus.wr_addr, prev_addr);
            check("hold_last", bus.wr_last, prev_last);
        end
        prev_hold = bus.wr_valid & ~bus.wr_ready & ~clear;
        prev_data = bus.wr_data;
        prev_addr = bus.wr_addr;
        prev_last = bus.wr_last;
        if (fire && !clear) begin
            if (exp_q.size() == 0) check("spurious_beat", 1, 0);
            else check("wr_data", bus.wr_data, exp_q.pop_front());
            check("wr_addr", bus.wr_addr, AW'(BASE + 64'(k % RW) * STEP));
            check("wr_last", bus.wr_last, (k % BL) == BL - 1);
            exp_wrap = (k % RW) == RW - 1;
            if (first_fire_cyc < 0) begin
                first_fire_cyc  = cyc;
                first_fire_addr = bus.wr_addr;
            end
            last_fire_cyc = cyc;
            k++;
            n_fired++;
        end else exp_wrap = 1'b0;
        if (clear) begin
            exp_q.delete();
            k = 0;
        end
        if (ren && first_ren_cyc < 0) first_ren_cyc = cyc;
        if (bus.wr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        @(posedge sdram_clk);
        #1;
        if (ren) begin
            bus.fifo_rdata = src_q.size() > 0 ? src_q.pop_front() : DW'($urandom);
            exp_q.push_back(bus.fifo_rdata);
        end else bus.fifo_rdata = DW'($urandom);
        last_ren = ren;
        check("wrap_pulse", wrap_pulse, exp_wrap);
        if (wrap_pulse) wraps++;
        check("words_written", words_written, 64'(n_fired));
        cyc++;
    endtask

    task automatic drain(input int budget, input bit rand_ready);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            bus.wr_ready = rand_ready ? 1'($urandom) : 1'b1;
            cycle();
            n++;
        end
        check("drain_timeout", n >= budget, 0);
    endtask

    task automatic mark_start();
        first_ren_cyc   = -1;
        first_valid_cyc = -1;
        first_fire_cyc  = -1;
        last_fire_cyc   = -1;
        wraps           = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int outstanding, base, ww, n;
        bus.wr_ready    = 1'b0;
        bus.fifo_rempty = 1'b1;
        bus.fifo_rdata  = '0;
        #12;
        check("rst_fifo_ren", bus.fifo_ren, 0);
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_wr_last", bus.wr_last, 0);
        check("rst_wrap", wrap_pulse, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_wr_addr", bus.wr_addr, BASE);
        check("rst_words", words_written, 0);
        check("rst_state", dut.state, ST_IDLE);
        rst_n = 1'b1;
        @(posedge sdram_clk);
        #1;

        // streaming with a region wrap
        mark_start();
        for (int i = 0; i < 20; i++) src_q.push_back(DW'(i));
        enable = 1'b1;
        drain(200, 1'b0);
        check("stream_latency", 64'(first_valid_cyc - first_ren_cyc), 2);
        check("stream_span", 64'(last_fire_cyc - first_fire_cyc), 19);
        check("wrap_count", 64'(wraps), 1);
        check("stream_words", words_written, 20);

        // random backpressure
        for (int i = 0; i < 100; i++) src_q.push_back(DW'($urandom));
        drain(2000, 1'b1);
        check("bp_words", words_written, 120);

        // FIFO empty gaps
        gap_mode = 1'b1;
        for (int i = 0; i < 60; i++) src_q.push_back(DW'($urandom));
        drain(2000, 1'b1);
        gap_mode = 1'b0;
        check("gap_words", words_written, 180);

        // enable drop with the buffer full
        for (int i = 0; i < 10; i++) src_q.push_back(DW'($urandom));
        bus.wr_ready = 1'b0;
        repeat (4) cycle();
        outstanding = exp_q.size();
        check("drop_outstanding", 64'(outstanding), 2);
        enable = 1'b0;
        base   = n_fired;
        cycle();
        check("drop_state", dut.state, ST_DRAIN);
        bus.wr_ready = 1'b1;
        repeat (10) cycle();
        check("drop_beats", 64'(n_fired - base), 64'(outstanding));
        check("drop_idle", dut.state, ST_IDLE);
        check("drop_left", 64'(src_q.size()), 8);
        src_q.delete();

        // clear mid-burst at idx 5 with two words buffered, same cycle as a fire
        enable = 1'b1;
        for (int i = 0; i < 30; i++) src_q.push_back(DW'($urandom));
        n = 0;
        while (!(k % RW == 5 && exp_q.size() - int'(last_ren) == 2) && n < 100) begin
            bus.wr_ready = k % RW != 5;
            cycle();
            n++;
        end
        check("clr_setup_timeout", n >= 100, 0);
        ww           = n_fired;
        clear        = 1'b1;
        bus.wr_ready = 1'b1;
        cycle();
        clear = 1'b0;
        check("clr_valid", bus.wr_valid, 0);
        check("clr_words", words_written, 64'(ww));
        check("clr_state", dut.state, ST_IDLE);
        mark_start();
        drain(300, 1'b1);
        check("clr_addr", first_fire_addr, BASE);

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 20; i++) src_q.push_back(DW'($urandom));
        bus.wr_ready = 1'b1;
        repeat (5) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_fifo_ren", bus.fifo_ren, 0);
        check("arst_wr_valid", bus.wr_valid, 0);
        check("arst_wr_last", bus.wr_last, 0);
        check("arst_wr_data", bus.wr_data, 0);
        check("arst_wr_addr", bus.wr_addr, BASE);
        check("arst_words", words_written, 0);
        enable = 1'b0;
        src_q.delete();
        exp_q.delete();
        k         = 0;
        n_fired   = 0;
        last_ren  = 1'b0;
        prev_hold = 1'b0;
        @(negedge sdram_clk);
        rst_n = 1'b1;
        @(posedge sdram_clk);
        #1;
        for (int i = 0; i < 4; i++) src_q.push_back(DW'($urandom));
        enable = 1'b1;
        drain(100, 1'b0);
        check("post_rst_words", words_written, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
